// File: rtl/cell_select_if.sv
// Mouse/board bundle between the pointer front end and the overlay chain.
interface cell_select_if;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        mouse_left;
    logic        enable;
    logic        clear;
    logic [8:0]  square;
    logic [8:0]  owner;
    logic        move_stb;
    logic [3:0]  move_idx;
    logic        turn;

    modport master (
        output xpos, ypos, mouse_left, enable, clear,
        input  square, owner, move_stb, move_idx, turn
    );

    modport slave (
        input  xpos, ypos, mouse_left, enable, clear,
        output square, owner, move_stb, move_idx, turn
    );
endinterface

// File: rtl/cell_select.sv
// Debounced click to 3x3 board cell mapper with occupancy/owner tracking.
module cell_select #(
    parameter int DEBOUNCE = 4,
    parameter int X0_END   = 339,
    parameter int X1_START = 343,
    parameter int X1_END   = 681,
    parameter int X2_START = 685,
    parameter int X2_END   = 1023,
    parameter int Y0_END   = 252,
    parameter int Y1_START = 257,
    parameter int Y1_END   = 510,
    parameter int Y2_START = 515,
    parameter int Y2_END   = 767
) (
    input  logic         pclk,
    input  logic         rst,
    cell_select_if.slave bus
);

    localparam logic [15:0] DEB_N = 16'(DEBOUNCE);
    localparam logic [11:0] X0E = 12'(X0_END);
    localparam logic [11:0] X1S = 12'(X1_START);
    localparam logic [11:0] X1E = 12'(X1_END);
    localparam logic [11:0] X2S = 12'(X2_START);
    localparam logic [11:0] X2E = 12'(X2_END);
    localparam logic [11:0] Y0E = 12'(Y0_END);
    localparam logic [11:0] Y1S = 12'(Y1_START);
    localparam logic [11:0] Y1E = 12'(Y1_END);
    localparam logic [11:0] Y2S = 12'(Y2_START);
    localparam logic [11:0] Y2E = 12'(Y2_END);

    typedef enum logic [1:0] {
        IDLE,
        DEB,
        COMMIT,
        WAIT_REL
    } state_t;

    state_t      state_q, state_d;
    logic        s1_q, s2_q;
    logic [15:0] cnt_q, cnt_d;
    logic [11:0] xl_q, xl_d;
    logic [11:0] yl_q, yl_d;
    logic [8:0]  sq_q, sq_d;
    logic [8:0]  own_q, own_d;
    logic        stb_q, stb_d;
    logic [3:0]  idx_q, idx_d;
    logic        turn_q, turn_d;

    logic        btn_s;
    logic [1:0]  col, row;
    logic        col_ok, row_ok;
    logic        cell_ok;
    logic [3:0]  idx;

    assign btn_s = s2_q;

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b0;
        unique case (1'b1)
            (xl_q <= X0E): begin
                col    = 2'd0;
                col_ok = 1'b1;
            end
            (xl_q >= X1S && xl_q <= X1E): begin
                col    = 2'd1;
                col_ok = 1'b1;
            end
            (xl_q >= X2S && xl_q <= X2E): begin
                col    = 2'd2;
                col_ok = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        row    = 2'd0;
        row_ok = 1'b0;
        unique case (1'b1)
            (yl_q <= Y0E): begin
                row    = 2'd0;
                row_ok = 1'b1;
            end
            (yl_q >= Y1S && yl_q <= Y1E): begin
                row    = 2'd1;
                row_ok = 1'b1;
            end
            (yl_q >= Y2S && yl_q <= Y2E): begin
                row    = 2'd2;
                row_ok = 1'b1;
            end
            default: ;
        endcase
    end

    assign cell_ok = col_ok && row_ok;
    assign idx = {1'b0, row, 1'b0} + {2'b00, row} + {2'b00, col};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xl_d    = xl_q;
        yl_d    = yl_q;
        sq_d    = sq_q;
        own_d   = own_q;
        stb_d   = 1'b0;
        idx_d   = idx_q;
        turn_d  = turn_q;
        unique case (state_q)
            IDLE: begin
                if (btn_s) begin
                    state_d = DEB;
                    cnt_d   = 16'd1;
                end
            end
            DEB: begin
                if (!btn_s) begin
                    state_d = IDLE;
                end else if (cnt_q == DEB_N) begin
                    state_d = COMMIT;
                    xl_d    = bus.xpos;
                    yl_d    = bus.ypos;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            COMMIT: begin
                state_d = WAIT_REL;
                if (bus.enable && cell_ok && !sq_q[idx]) begin
                    sq_d[idx]  = 1'b1;
                    own_d[idx] = turn_q;
                    idx_d      = idx;
                    stb_d      = 1'b1;
                    turn_d     = !turn_q;
                end
            end
            WAIT_REL: begin
                if (!btn_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A clear on the commit edge cancels the move entirely.
        if (bus.clear) begin
            sq_d   = '0;
            own_d  = '0;
            turn_d = 1'b0;
            stb_d  = 1'b0;
            idx_d  = idx_q;
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            xl_q    <= '0;
            yl_q    <= '0;
            sq_q    <= '0;
            own_q   <= '0;
            stb_q   <= 1'b0;
            idx_q   <= '0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= bus.mouse_left;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            xl_q    <= xl_d;
            yl_q    <= yl_d;
            sq_q    <= sq_d;
            own_q   <= own_d;
            stb_q   <= stb_d;
            idx_q   <= idx_d;
            turn_q  <= turn_d;
        end
    end

    assign bus.square   = sq_q;
    assign bus.owner    = own_q;
    assign bus.move_stb = stb_q;
    assign bus.move_idx = idx_q;
    assign bus.turn     = turn_q;

endmodule

// File: doc/cell_select.md
Name: cell_select

Overview:
- Front end of the board overlay chain: turns mouse position and left-button activity into the per-cell level flags that the `draw_squareN` overlay stages consume.
- Debounces and edge-qualifies the click, maps it to one of 9 board cells, and rejects gaps and occupied cells.
- Keeps a 9-bit occupancy mask and an owner mask, alternates players per accepted move, and pulses a move strobe for game logic.

Parameters:
- DEBOUNCE, 4, consecutive synchronised-high cycles required to accept a press (1..65535).
- X0_END, 339, last hcount of column 0 (column 0 starts at 0).
- X1_START, 343, first hcount of column 1.
- X1_END, 681, last hcount of column 1.
- X2_START, 685, first hcount of column 2.
- X2_END, 1023, last hcount of column 2.
- Y0_END, 252, last vcount of row 0 (row 0 starts at 0).
- Y1_START, 257, first vcount of row 1.
- Y1_END, 510, last vcount of row 1.
- Y2_START, 515, first vcount of row 2.
- Y2_END, 767, last vcount of row 2.

Ports:
- pclk  input  1  pixel clock, single clock domain.
- rst  input  1  synchronous, active-low reset (rst==0 at a pclk edge resets).
- xpos  input  12  mouse x, pixel units.
- ypos  input  12  mouse y, pixel units.
- mouse_left  input  1  raw left button, may be asynchronous.
- enable  input  1  1 = moves accepted (game running).
- clear  input  1  1-cycle pulse: empty the board for a new game.
- square  output  9  occupancy; bit k drives draw_square(k+1); bit 8 = square9.
- owner  output  9  per-cell player (0 = X, 1 = O); valid only where square=1.
- move_stb  output  1  one-cycle pulse per accepted move.
- move_idx  output  4  index 0..8 of the last accepted move; held between moves.
- turn  output  1  player making the next move.

Behaviour:
- Reset (rst==0 at an edge): square=0, owner=0, move_stb=0, move_idx=0, turn=0, state=IDLE, synchroniser=0, counter=0. Reset mid-operation aborts any press in progress and no move is produced.
- mouse_left passes through a 2-flop synchroniser to give btn_s; there is no other use of the raw input.
- State machine IDLE, DEB, COMMIT, WAIT_REL:
  - IDLE: if btn_s=1, go to DEB with cnt=1.
  - DEB: if btn_s=0, go to IDLE. Else if cnt==DEBOUNCE, go to COMMIT and latch xpos/ypos into x_l/y_l. Else cnt<=cnt+1.
  - COMMIT: always go to WAIT_REL next edge. If enable=1, the cell is valid and square[idx]==0, then set square[idx]=1, owner[idx]=turn, move_idx=idx, move_stb=1, and toggle turn.
  - WAIT_REL: stay while btn_s=1. Go to IDLE after btn_s==0 is seen. A held button yields exactly one move attempt.
- Cell decode from latched x_l/y_l, inclusive ranges:
  - col 0: 0..X0_END; col 1: X1_START..X1_END; col 2: X2_START..X2_END.
  - Rows use the same pattern with the Y parameters.
  - idx = row*3 + col.
  - Any coordinate in a gap or beyond X2_END/Y2_END is invalid: no state change except entering WAIT_REL.
- Width rules: compare full 12 bits, with no truncation to 11 bits; xpos=2048 is invalid, not aliased. cnt is 16 bits.
- move_stb is registered and high for exactly the one cycle following the COMMIT edge; it is 0 in every other cycle.
- Latency: with mouse_left high from the edge-1 sample onward, COMMIT is entered at edge DEBOUNCE+3. Outputs update at edge DEBOUNCE+4.
- A btn_s low for even one cycle during DEB restarts the debounce.
- clear=1 at an edge: square=0, owner=0, turn=0. State machine and move_idx are unchanged.
- clear and an accepted COMMIT on the same edge: clear wins. Board ends empty, move_stb=0, turn=0.
- enable=0 in COMMIT: click is discarded with no outputs changed. The FSM still waits for release.
- Board full: every click is rejected as occupied. No auto-clear.

Test Plan:
1. Reset held 3 cycles, then release with DEBOUNCE=4. Click at (800,600), held 20 cycles → move_stb high for 1 cycle after edge 8; move_idx=8; square=9'h100; owner[8]=0; turn=1.
2. Same cell clicked again at (700,520) → no move_stb; square still 9'h100; turn still 1.
3. Click at (341,100) (column gap) → no move_stb and no state change. Then (100,100) → move_idx=0, square=9'h101, owner[0]=1, turn=0.
4. Button high 3 cycles, low 1, high 2, low (bounce) → no move. Hold 10 cycles at (500,300) → exactly one move_stb, move_idx=4.
5. clear asserted on the same edge COMMIT would accept cell 4 → square=0, owner=0, turn=0, move_stb stays 0.
6. rst driven low during DEB and during WAIT_REL → all outputs at reset values next edge; no move_stb. With enable=0 and a valid click → nothing changes.
